// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst arbiter merging N_CH upstream FIFOs into one registered stream
module fifo_rr_arbiter #(
  parameter int Nb    = 8,
  parameter int N_CH  = 4,
  parameter int BURST = 4,
  parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      chan_en,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH*Nb-1:0]   in_data,
  output logic [N_CH-1:0]      in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Nb-1:0]        out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 busy,
  output logic [CW-1:0]        grant
);

  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   last;
  logic [CW-1:0]   sel;
  logic [CW-1:0]   idx;
  logic            found;
  logic [BW-1:0]   beat;
  logic [N_CH-1:0] req;
  logic            pop_ok;
  logic            cur_valid;
  logic [Nb-1:0]   cur_word;
  logic            xfer;
  logic            drained;
  logic            burst_done;

  assign req = in_valid & chan_en;

  // Pick the first requesting channel after the last one served, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CW'((int'(last) + k) % N_CH);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Select the valid flag and word of the granted channel.
  always_comb begin
    cur_valid = 1'b0;
    cur_word  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CW'(i)) begin
        cur_valid = in_valid[i];
        cur_word  = in_data[i*Nb +: Nb];
      end
    end
  end

  // The output register can take a new word when empty or being drained this cycle.
  assign pop_ok     = !out_valid || out_ready;
  assign busy       = (state == GRANT);
  assign xfer       = busy && pop_ok && cur_valid;
  // A stall due only to backpressure keeps the grant; an empty channel ends it.
  assign drained    = busy && pop_ok && !cur_valid;
  assign burst_done = xfer && (beat == BW'(BURST - 1));

  // Next-state decode and the pop strobe toward the granted channel.
  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    case (state)
      IDLE: begin
        if (found) state_nxt = GRANT;
      end
      GRANT: begin
        if (pop_ok) in_ready = N_CH'(1) << grant;
        if (burst_done || drained) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state: FSM, current grant, round-robin pointer and beat count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= CW'(N_CH - 1);
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) grant <= sel;
      if (busy && (burst_done || drained)) begin
        last <= grant;
        beat <= '0;
      end else if (xfer) begin
        beat <= beat + BW'(1);
      end
    end
  end

  // Output register: load on transfer, clear valid once accepted with nothing new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cur_word;
      out_chan  <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  chan_en;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        busy;
  logic [1:0]  grant;

  fifo_rr_arbiter #(.Nb(8), .N_CH(4), .BURST(4)) dut (
    .clk(clk), .reset(reset), .chan_en(chan_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [4][32];
  int         wr [4];
  int         rd [4];
  int         cyc;
  int         pop_cyc [64];
  int         pop_n;
  logic [7:0] obs_d [64];
  logic [1:0] obs_c [64];
  int         obs_n;
  logic [1:0] gr_log [16];
  int         gr_n;
  logic       prev_busy;
  int         ready02;
  int         onehot_bad;
  logic [3:0] pop_mask;
  int         k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]       = (rd[i] < wr[i]);
      in_data[i*8 +: 8] = (rd[i] < wr[i]) ? mem[i][rd[i]] : 8'h00;
    end
  endtask

  task automatic load(input int ch, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) begin
      mem[ch][wr[ch]] = base + 8'(j);
      wr[ch]++;
    end
    drive();
  endtask

  // One clock: observe at the falling edge, update upstream FIFOs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    pop_mask = in_ready & in_valid;
    if (pop_mask != 4'b0 && pop_n < 64) begin
      pop_cyc[pop_n] = cyc;
      pop_n++;
    end
    if ($countones(in_ready) > 1) onehot_bad++;
    if (in_ready[0] || in_ready[2]) ready02++;
    if (out_valid && out_ready && obs_n < 64) begin
      obs_c[obs_n] = out_chan;
      obs_d[obs_n] = out_data;
      obs_n++;
    end
    if (busy && !prev_busy && gr_n < 16) begin
      gr_log[gr_n] = grant;
      gr_n++;
    end
    prev_busy = busy;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (pop_mask[i]) rd[i]++;
    drive();
    #1;
  endtask

  initial begin
    reset = 1'b0; chan_en = 4'hF; out_ready = 1'b1; in_valid = '0; in_data = '0;
    for (int i = 0; i < 4; i++) begin wr[i] = 0; rd[i] = 0; end
    cyc = 0; pop_n = 0; obs_n = 0; gr_n = 0; prev_busy = 1'b0; ready02 = 0; onehot_bad = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_out_data", out_data, 0);

    // Four channels, six words each, full throughput downstream.
    load(0, 6, 8'h00); load(1, 6, 8'h10); load(2, 6, 8'h20); load(3, 6, 8'h30);
    tick();
    reset = 1'b1;
    pop_n = 0; obs_n = 0; cyc = 0;
    repeat (45) tick();
    chk("s034_count", obs_n, 24);
    chk("s034_pops", pop_n, 24);
    k = 0;
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < 4; ch++)
        for (int b = (r == 0 ? 0 : 4); b < (r == 0 ? 4 : 6); b++) begin
          chk("s034_chan", obs_c[k], ch);
          chk("s034_data", obs_d[k], ch * 16 + b);
          k++;
        end
    chk("s034_gap_r1", pop_cyc[4] - pop_cyc[3], 2);
    chk("s034_gap_r2", pop_cyc[16] - pop_cyc[15], 2);
    chk("s034_span", pop_cyc[23] - pop_cyc[0], 33);
    chk("s034_busy_end", busy, 0);
    chk("s034_ov_end", out_valid, 0);

    // Only channel 2 requests, two words.
    obs_n = 0;
    load(2, 2, 8'h80);
    tick();
    chk("s035_busy", busy, 1);
    chk("s035_grant", grant, 2);
    chk("s035_ready0", in_ready, 4'b0100);
    chk("s035_ov0", out_valid, 0);
    tick();
    chk("s035_ready1", in_ready, 4'b0100);
    chk("s035_ov1", out_valid, 1);
    chk("s035_d0", out_data, 8'h80);
    chk("s035_c0", out_chan, 2);
    tick();
    chk("s035_d1", out_data, 8'h81);
    chk("s035_busy_drain", busy, 1);
    tick();
    chk("s035_idle", busy, 0);
    chk("s035_ov_idle", out_valid, 0);
    chk("s035_ready_idle", in_ready, 0);
    repeat (3) tick();
    chk("s035_still_idle", busy, 0);
    chk("s035_grant_hold", grant, 2);
    chk("s035_count", obs_n, 2);

    // Channel 1 burst with downstream stalled for five cycles after the first word.
    obs_n = 0;
    load(1, 4, 8'hA0);
    tick();
    chk("s036_busy", busy, 1);
    chk("s036_grant", grant, 1);
    chk("s036_ready", in_ready, 4'b0010);
    out_ready = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      chk("s036_stall_ov", out_valid, 1);
      chk("s036_stall_data", out_data, 8'hA0);
      chk("s036_stall_chan", out_chan, 1);
      chk("s036_stall_ready", in_ready, 0);
      chk("s036_stall_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    repeat (6) tick();
    chk("s036_count", obs_n, 4);
    for (int j = 0; j < 4; j++) begin
      chk("s036_chan", obs_c[j], 1);
      chk("s036_data", obs_d[j], 32'hA0 + j);
    end
    chk("s036_busy_end", busy, 0);

    // Fresh reset, then only channels 1 and 3 enabled while all four request.
    reset = 1'b0;
    tick();
    chan_en = 4'b1010;
    load(0, 4, 8'h50); load(1, 8, 8'hB0); load(2, 4, 8'h60); load(3, 8, 8'hD0);
    reset = 1'b1;
    obs_n = 0; gr_n = 0; ready02 = 0;
    repeat (40) tick();
    chk("s037_grants", gr_n, 4);
    chk("s037_g0", gr_log[0], 1);
    chk("s037_g1", gr_log[1], 3);
    chk("s037_g2", gr_log[2], 1);
    chk("s037_g3", gr_log[3], 3);
    chk("s037_disabled_ready", ready02, 0);
    chk("s037_count", obs_n, 16);
    k = 0;
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 4; b++) begin
        chk("s037_chan", obs_c[k], (j % 2 == 0) ? 1 : 3);
        chk("s037_data", obs_d[k], ((j % 2 == 0) ? 32'hB0 : 32'hD0) + (j / 2) * 4 + b);
        k++;
      end
    chk("s037_busy_end", busy, 0);

    // Reset asserted during the second beat of a channel 3 burst.
    chan_en = 4'b1000;
    load(3, 4, 8'hE0);
    tick();
    chk("s038_busy", busy, 1);
    chk("s038_grant", grant, 3);
    tick();
    chk("s038_ov_pre", out_valid, 1);
    chk("s038_d_pre", out_data, 8'hE0);
    chk("s038_ready_pre", in_ready, 4'b1000);
    reset = 1'b0;
    #1;
    chk("s038_ov_rst", out_valid, 0);
    chk("s038_ready_rst", in_ready, 0);
    chk("s038_busy_rst", busy, 0);
    chk("s038_data_rst", out_data, 0);
    chk("s038_grant_rst", grant, 0);
    chan_en = 4'hF;
    obs_n = 0;
    tick();
    reset = 1'b1;
    tick();
    chk("s038_busy_rel", busy, 1);
    chk("s038_grant_rel", grant, 0);
    chk("s038_ready_rel", in_ready, 4'b0001);
    chk("s038_ov_rel", out_valid, 0);
    repeat (30) tick();
    chk("s038_count", obs_n, 11);
    for (int j = 0; j < 4; j++) begin
      chk("s038_c_ch0", obs_c[j], 0);
      chk("s038_d_ch0", obs_d[j], 32'h50 + j);
      chk("s038_c_ch2", obs_c[4 + j], 2);
      chk("s038_d_ch2", obs_d[4 + j], 32'h60 + j);
    end
    for (int j = 0; j < 3; j++) begin
      chk("s038_c_ch3", obs_c[8 + j], 3);
      chk("s038_d_ch3", obs_d[8 + j], 32'hE1 + j);
    end
    chk("onehot_ready", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
